// File: rtl/voting_machine_multi.sv
// Multi-candidate voting machine: one ballot per admin press, saturating per-candidate tallies, leader/tie.
// Optional ballot expiry is compiled in with `define EVM_TIMEOUT_EN.
module voting_machine_multi #(
  parameter int NCAND   = 4,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1000,
  localparam int SW = $clog2(NCAND),
  localparam int TW = CNT_W + SW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             admin,
  input  logic [NCAND-1:0] vote,
  input  logic             clear,
  input  logic [SW-1:0]    sel,
  output logic             led_armed,
  output logic             led_cast,
  output logic             invalid,
  output logic [CNT_W-1:0] sel_count,
  output logic [TW-1:0]    total,
  output logic [SW-1:0]    leader,
  output logic             tie,
  output logic             timeout_flag
);

  typedef enum logic [1:0] {IDLE, ARMED, CAST} state_t;

  state_t           state_reg, state_next;
  logic             admin_reg, primed_reg;
  logic [NCAND-1:0] vote_reg;
  logic [CNT_W-1:0] tally_reg  [NCAND];
  logic [CNT_W-1:0] tally_next [NCAND];
  logic [TW-1:0]    total_reg;
  logic [SW-1:0]    leader_reg, leader_next;
  logic             tie_reg, tie_next, led_cast_reg, invalid_reg;
  logic             admin_edge, vote_edge, vote_onehot, vote_sat;
  logic             accept, reject, arm, clear_do, timeout_hit;
  logic [SW-1:0]    vote_idx;
  logic [CNT_W-1:0] max_val;
  int               n_max;

  if (NCAND < 2 || NCAND > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("voting_machine_multi: NCAND must be 2..16 and TIMEOUT >= 1");
  end

  // primed_reg masks the first cycle after reset so buttons held through reset never look like edges
  assign admin_edge  = primed_reg & admin & ~admin_reg;
  assign vote_edge   = primed_reg & (|(vote & ~vote_reg));
  assign vote_onehot = $onehot(vote);

  always_comb begin
    vote_idx = '0;
    for (int i = 0; i < NCAND; i++)
      if (vote[i]) vote_idx = SW'(i);
  end

  assign vote_sat = (tally_reg[vote_idx] == {CNT_W{1'b1}});
  assign accept   = (state_reg == ARMED) && vote_edge && vote_onehot && !vote_sat;
  assign reject   = vote_edge && !accept;
  assign arm      = admin_edge && (state_reg != ARMED);
  assign clear_do = clear && (state_reg == IDLE);

  for (genvar gi = 0; gi < NCAND; gi++) begin : g_tally
    assign tally_next[gi] = clear_do            ? '0 :
                            (accept && vote[gi]) ? tally_reg[gi] + 1'b1 : tally_reg[gi];
  end

`ifdef EVM_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tmo_cnt_reg;
  logic           timeout_flag_reg;

  assign timeout_hit  = (state_reg == ARMED) && !accept && (tmo_cnt_reg == TCW'(TIMEOUT - 1));
  assign timeout_flag = timeout_flag_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_reg      <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= (state_reg == ARMED && state_next == ARMED) ? tmo_cnt_reg + 1'b1 : '0;
      if (arm)              timeout_flag_reg <= 1'b0;
      else if (timeout_hit) timeout_flag_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (accept) state_next = CAST;
               else if (timeout_hit) state_next = IDLE;
      CAST:    if (arm) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  // Strict '>' keeps the lowest index on ties
  always_comb begin
    max_val     = tally_reg[0];
    leader_next = '0;
    n_max       = 0;
    for (int i = 1; i < NCAND; i++)
      if (tally_reg[i] > max_val) begin
        max_val     = tally_reg[i];
        leader_next = SW'(i);
      end
    for (int i = 0; i < NCAND; i++)
      if (tally_reg[i] == max_val) n_max = n_max + 1;
    tie_next = (max_val != '0) && (n_max > 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      admin_reg    <= 1'b0;
      vote_reg     <= '0;
      primed_reg   <= 1'b0;
      total_reg    <= '0;
      leader_reg   <= '0;
      tie_reg      <= 1'b0;
      led_cast_reg <= 1'b0;
      invalid_reg  <= 1'b0;
      for (int i = 0; i < NCAND; i++) tally_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      admin_reg  <= admin;
      vote_reg   <= vote;
      primed_reg <= 1'b1;
      tally_reg  <= tally_next;
      if (clear_do)    total_reg <= '0;
      else if (accept) total_reg <= total_reg + 1'b1;
      if (clear_do) begin
        leader_reg <= '0;
        tie_reg    <= 1'b0;
      end else begin
        leader_reg <= leader_next;
        tie_reg    <= tie_next;
      end
      if (arm)         led_cast_reg <= 1'b0;
      else if (accept) led_cast_reg <= 1'b1;
      // a rejected vote in the arming cycle must still leave invalid set
      if (reject)      invalid_reg <= 1'b1;
      else if (arm)    invalid_reg <= 1'b0;
    end
  end

  assign led_armed = (state_reg == ARMED);
  assign led_cast  = led_cast_reg;
  assign invalid   = invalid_reg;
  assign total     = total_reg;
  assign leader    = leader_reg;
  assign tie       = tie_reg;
  assign sel_count = (int'(sel) < NCAND) ? tally_reg[sel] : '0;

endmodule

// File: doc/voting_machine_multi.md
VOTING_MACHINE_MULTI -- requirements
Module: voting_machine_multi

Interface
REQ-001 SHALL have parameter NCAND, default 4, number of candidates (2..16).
REQ-002 SHALL have parameter CNT_W, default 10, per-candidate tally width.
REQ-003 SHALL have parameter TIMEOUT, default 1000, ballot expiry in clk cycles (used only with EVM_TIMEOUT_EN).
REQ-004 SHALL define SW = ceil(log2(NCAND)) and TW = CNT_W+SW as derived widths.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port admin, input, 1, arms one ballot on its rising edge.
REQ-008 SHALL have port vote, input, NCAND, candidate buttons, bit i = candidate i.
REQ-009 SHALL have port clear, input, 1, zeroes all tallies.
REQ-010 SHALL have port sel, input, SW, selects the candidate shown on sel_count.
REQ-011 SHALL have port led_armed, output, 1, high while a ballot is armed.
REQ-012 SHALL have port led_cast, output, 1, high from an accepted vote until the next arm.
REQ-013 SHALL have port invalid, output, 1, sticky rejected-vote flag.
REQ-014 SHALL have port sel_count, output, CNT_W, tally of candidate sel (combinational mux; 0 if sel >= NCAND).
REQ-015 SHALL have port total, output, TW, sum of all accepted votes.
REQ-016 SHALL have port leader, output, SW, index of the highest tally.
REQ-017 SHALL have port tie, output, 1, high when the maximum tally is shared.
REQ-018 SHALL have port timeout_flag, output, 1, ballot expired.

Function
REQ-019 SHALL register admin and vote each cycle; edge = input high and registered copy low.
REQ-020 SHALL implement FSM IDLE -> ARMED on admin edge; ARMED -> CAST on accepted vote; CAST -> ARMED on admin edge; admin edge in ARMED ignored.
REQ-021 SHALL accept a vote only when state is ARMED, any vote edge occurs, vote level is exactly one-hot and that tally < 2^CNT_W-1.
REQ-022 SHALL, on acceptance, increment that tally and total and set led_cast at the same clk edge (visible next cycle).
REQ-023 SHALL, on any vote edge that is not accepted (state not ARMED, multi-hot level, or saturated tally), set invalid, leave all tallies unchanged and keep the state.
REQ-024 SHALL clear invalid, led_cast and timeout_flag on an arm transition; a simultaneous invalid-setting event wins and invalid ends high.
REQ-025 SHALL judge a vote edge coinciding with an admin edge against the pre-edge state; for IDLE/CAST this arms and sets invalid.
REQ-026 SHALL update leader and tie one cycle after any tally change; ties break to the lowest index; tie = 0 when all tallies are 0.
REQ-027 SHALL apply clear only in IDLE: tallies, total, leader and tie are 0 next cycle; clear in other states is ignored without setting invalid.
REQ-028 SHALL drive led_armed = (state == ARMED).

Reset
REQ-029 SHALL, on reset_n low, immediately force state IDLE, all tallies, total, leader, tie, led_armed, led_cast, invalid, timeout_flag and the edge-detect registers to 0.
REQ-030 SHALL discard an armed or in-progress ballot on reset mid-operation; buttons held through reset release produce no edge.

Configuration
REQ-031 SHALL, with macro EVM_TIMEOUT_EN defined, count cycles in ARMED and, after TIMEOUT cycles without an accepted vote, return to IDLE and set timeout_flag until the next arm.
REQ-032 SHALL, without EVM_TIMEOUT_EN, omit the counter, tie timeout_flag to 0 and hold ARMED indefinitely.

Verification
REQ-033 SHALL cover: reset, admin pulse, vote=0100 -> tally[2]=1, total=1, led_cast=1, leader=2, tie=0.
REQ-034 SHALL cover: armed, vote=0110 -> invalid=1, tallies unchanged, led_armed=1; then vote=0001 -> tally[0]=1, invalid stays 1 until next arm.
REQ-035 SHALL cover: vote=0001 in IDLE with no admin -> invalid=1, total=0; admin+vote=0001 same cycle from CAST -> armed, invalid=1, no increment.
REQ-036 SHALL cover: CNT_W=2, four ballots for candidate 1 -> tally[1]=3 saturated, fourth sets invalid; tallies {1,3,0,3} -> leader=1, tie=1.
REQ-037 SHALL cover: EVM_TIMEOUT_EN, TIMEOUT=8, arm and wait 8 cycles -> IDLE, timeout_flag=1; reset_n low mid-ballot -> all outputs 0 asynchronously.
